mesi_cpu_agent: RTL and testbench
=================================

MESI_CPU_AGENT -- requirements
Module: mesi_cpu_agent

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, byte address width on the CPU, main bus and coherence bus.
REQ-002 Parameter: LINES, default 16, number of tracked lines; power of two, at least 2.
REQ-003 Parameter: WB_CYCLES, default 4, writeback stall in cycles; range 1..15.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Port: clk, in, 1, system clock.
REQ-006 Port: rst, in, 1, asynchronous active-low reset.
REQ-007 Port: cpu_req_i, in, 1, CPU access request; held until cpu_done_o.
REQ-008 Port: cpu_wr_i, in, 1, access type; 1 = write, 0 = read.
REQ-009 Port: cpu_addr_i, in, ADDR_WIDTH, access address.
REQ-010 Port: cpu_done_o, out, 1, one-cycle access-complete pulse.
REQ-011 Port: mbus_cmd_o, out, 3, main bus command to the coherence controller.
REQ-012 Port: mbus_addr_o, out, ADDR_WIDTH, main bus address.
REQ-013 Port: mbus_ack_i, in, 1, one-cycle main bus acknowledge.
REQ-014 Port: cbus_cmd_i, in, 3, coherence command from the controller.
REQ-015 Port: cbus_addr_i, in, ADDR_WIDTH, coherence address.
REQ-016 Port: cbus_ack_o, out, 1, one-cycle coherence acknowledge.

Function
REQ-017 Line index SHALL be addr[log2(LINES)+1:2]; tag SHALL be the address bits above the index; each line SHALL hold a 2-bit MESI state (I=0, S=1, E=2, M=3) and a tag.
REQ-018 Hit SHALL mean tag equal and state not I.
REQ-019 Request FSM states: IDLE, WB, BCAST, WAIT_EN, DONE.
REQ-020 In IDLE, with cpu_req_i high: read hit, or write hit in M or E, SHALL go to DONE; a write hit in E SHALL set the line to M.
REQ-021 Otherwise, if the victim line is M with a different tag, the FSM SHALL go to WB; else it SHALL go to BCAST.
REQ-022 WB SHALL drive mbus_cmd_o=WR (1) with the victim address until mbus_ack_i, then set the victim to I and go to BCAST.
REQ-023 BCAST SHALL drive WR_BROAD (3) for a write or RD_BROAD (4) for a read, with cpu_addr_i, until mbus_ack_i, then go to WAIT_EN.
REQ-024 Main bus commands SHALL be held stable until acknowledged; mbus_cmd_o SHALL be NOP (0) in every other state.
REQ-025 WAIT_EN SHALL wait for cbus EN_WR (3) or EN_RD (4) at its own address, ack it, write the tag, set the state to M (EN_WR) or S (EN_RD), and go to DONE.
REQ-026 DONE SHALL pulse cpu_done_o for one cycle and return to IDLE.
REQ-027 Snoop FSM states: S_IDLE, S_WB, S_ACK; it SHALL run independently of the request FSM and be serviceable in every request state.
REQ-028 WR_SNOOP (1) or RD_SNOOP (2) hitting a line in M SHALL go to S_WB, otherwise straight to S_ACK.
REQ-029 In S_ACK, cbus_ack_o SHALL be high for exactly one cycle.
REQ-030 On that ack, a hit line SHALL go to I for WR_SNOOP, and to S for RD_SNOOP from M or E.
REQ-031 A snoop miss SHALL be acked with no state change.
REQ-032 cbus_ack_o SHALL be asserted at most once per command; the controller drops cbus_cmd_i the cycle after the ack, and the agent SHALL ignore cbus_cmd_i during that cycle.
REQ-033 Simultaneous table writes to the same line SHALL resolve with the snoop update first and the request update applied last.
REQ-034 A request hit/miss decision SHALL NOT be taken in a cycle where a snoop is in S_ACK on the same index; the FSM SHALL re-evaluate the next cycle.
REQ-035 EN_WR or EN_RD SHALL be acked by the request FSM only in WAIT_EN; any other unexpected EN SHALL be acked with no state change.

Reset
REQ-036 While rst is low, all states SHALL be I, both FSMs SHALL be idle, and cpu_done_o, cbus_ack_o, mbus_cmd_o and mbus_addr_o SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon it with no ack or done pulse.
REQ-038 The first command SHALL be accepted on the second clock edge after rst rises.

Configuration
REQ-039 Macro MESI_SNOOP_WB_EN: when defined, S_WB SHALL count WB_CYCLES cycles before S_ACK.
REQ-040 When MESI_SNOOP_WB_EN is undefined, S_WB SHALL last exactly one cycle.

Structure
REQ-041 A shared package mesi_pkg SHALL hold the MBUS/CBUS command encodings, the MESI state enum and the command width of 3.
REQ-042 The line table SHALL be a sub-module mesi_line_table with one combinational lookup port per FSM and a prioritised write port.

Verification
REQ-043 Read 0x40 from reset -> RD_BROAD 0x40 until ack; EN_RD 0x40 acked 1 cycle later; done; line S.
REQ-044 Write 0x40 after EN_WR fill -> line M; a second write 0x40 completes in 2 cycles with no mbus activity.
REQ-045 RD_SNOOP 0x40 on an M line with macro set, WB_CYCLES=4 -> ack 5 cycles after the command; line S.
REQ-046 Read 0x440 with LINES=16 while 0x40 is M -> WR 0x40 first, then RD_BROAD 0x440.
REQ-047 WR_SNOOP 0x80 while the request FSM sits in WAIT_EN for 0x40 -> snoop acked; then EN_RD 0x40 completes normally.
REQ-048 Reset asserted during BCAST -> mbus_cmd_o reads 0 immediately; no cpu_done_o pulse.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared MESI encodings: bus command codes, line-state enum and command width.
// Pure definitions with no timing or flow-control behaviour.
package mesi_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        MBUS_NOP      = 3'd0,
        MBUS_WR       = 3'd1,
        MBUS_WR_BROAD = 3'd3,
        MBUS_RD_BROAD = 3'd4
    } mbus_cmd_e;

    typedef enum logic [CMD_W-1:0] {
        CBUS_NOP      = 3'd0,
        CBUS_WR_SNOOP = 3'd1,
        CBUS_RD_SNOOP = 3'd2,
        CBUS_EN_WR    = 3'd3,
        CBUS_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    function automatic logic is_en(input logic [CMD_W-1:0] cmd);
        return (cmd == CBUS_EN_WR) || (cmd == CBUS_EN_RD);
    endfunction

    function automatic logic is_snoop(input logic [CMD_W-1:0] cmd);
        return (cmd == CBUS_WR_SNOOP) || (cmd == CBUS_RD_SNOOP);
    endfunction

endpackage

// File: rtl/mesi_line_table.sv
// Per-line MESI state and tag store: two combinational lookup ports, one write port per FSM.
// Writes land on the next edge; the request write is applied after the snoop write so it wins on the same line.
module mesi_line_table
    import mesi_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 26,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] req_ridx_i,
    output logic [1:0]       req_state_o,
    output logic [TAG_W-1:0] req_tag_o,
    input  logic [IDX_W-1:0] snp_ridx_i,
    output logic [1:0]       snp_state_o,
    output logic [TAG_W-1:0] snp_tag_o,
    input  logic             snp_we_i,
    input  logic [IDX_W-1:0] snp_widx_i,
    input  logic [1:0]       snp_wstate_i,
    input  logic             req_we_i,
    input  logic [IDX_W-1:0] req_widx_i,
    input  logic [1:0]       req_wstate_i,
    input  logic [TAG_W-1:0] req_wtag_i
);

    mesi_e            state_q [LINES];
    logic [TAG_W-1:0] tag_q   [LINES];

    assign req_state_o = state_q[req_ridx_i];
    assign req_tag_o   = tag_q[req_ridx_i];
    assign snp_state_o = state_q[snp_ridx_i];
    assign snp_tag_o   = tag_q[snp_ridx_i];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= MESI_I;
                tag_q[i]   <= '0;
            end
        end else begin
            if (snp_we_i) begin
                state_q[snp_widx_i] <= mesi_e'(snp_wstate_i);
            end
            // Last non-blocking write wins: request update overrides a same-line snoop update.
            if (req_we_i) begin
                state_q[req_widx_i] <= mesi_e'(req_wstate_i);
                tag_q[req_widx_i]   <= req_wtag_i;
            end
        end
    end

endmodule

// File: rtl/mesi_cpu_agent.sv
// CPU-side MESI agent: request FSM (hits, victim writeback, broadcast, fill) plus an independent snoop FSM.
// Hits finish in 2 cycles; mbus commands held until mbus_ack_i; MESI_SNOOP_WB_EN stretches snoop writeback to WB_CYCLES.
module mesi_cpu_agent
    import mesi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINES      = 16,
    parameter int WB_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_wr_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    output logic                  cpu_done_o,
    output logic [2:0]            mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0] mbus_addr_o,
    input  logic                  mbus_ack_i,
    input  logic [2:0]            cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
    output logic                  cbus_ack_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam int CNT_W = $clog2(WB_CYCLES + 1);
`ifdef MESI_SNOOP_WB_EN
    localparam int SWB_CYCLES = WB_CYCLES;
`else
    localparam int SWB_CYCLES = 1;
`endif
    localparam logic [CNT_W-1:0] SWB_LAST = CNT_W'(SWB_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WB, BCAST, WAIT_EN, DONE} req_st_e;
    typedef enum logic [1:0] {S_IDLE, S_WB, S_ACK} snp_st_e;

    req_st_e               req_q, req_d;
    snp_st_e               snp_q, snp_d;
    logic                  rdy_q;
    logic                  en_ack_q, en_ack_d;
    logic                  cbus_ign_q;
    logic [CMD_W-1:0]      snp_cmd_q, snp_cmd_d;
    logic [ADDR_WIDTH-1:0] snp_addr_q, snp_addr_d;
    logic [CNT_W-1:0]      swb_cnt_q, swb_cnt_d;

    logic [IDX_W-1:0]      req_idx, snp_idx;
    logic [TAG_W-1:0]      req_tag, snp_tag, tbl_req_tag, tbl_snp_tag;
    logic [1:0]            tbl_req_st, tbl_snp_st;
    logic [ADDR_WIDTH-1:0] snp_look_addr;
    logic                  req_hit, snp_hit, snp_block, en_match, cbus_busy;

    logic                  snp_we, req_we;
    logic [1:0]            snp_wstate, req_wstate;
    logic [TAG_W-1:0]      req_wtag;
    mbus_cmd_e             mbus_cmd;
    logic [ADDR_WIDTH-1:0] mbus_addr;

    assign req_idx = cpu_addr_i[IDX_W+1:2];
    assign req_tag = cpu_addr_i[ADDR_WIDTH-1:IDX_W+2];
    // Snoop lookup follows the live bus while idle, then the latched command address.
    assign snp_look_addr = (snp_q == S_IDLE) ? cbus_addr_i : snp_addr_q;
    assign snp_idx       = snp_look_addr[IDX_W+1:2];
    assign snp_tag       = snp_look_addr[ADDR_WIDTH-1:IDX_W+2];

    assign req_hit   = (tbl_req_st != MESI_I) && (tbl_req_tag == req_tag);
    assign snp_hit   = (tbl_snp_st != MESI_I) && (tbl_snp_tag == snp_tag);
    assign snp_block = (snp_q == S_ACK) && (snp_addr_q[IDX_W+1:2] == req_idx);

    assign cbus_ack_o = (snp_q == S_ACK) || en_ack_q;
    // The controller holds its command through the ack cycle and the one after it.
    assign cbus_busy  = cbus_ack_o || cbus_ign_q;
    assign en_match   = rdy_q && !cbus_busy && (req_q == WAIT_EN) && is_en(cbus_cmd_i)
                        && (cbus_addr_i == cpu_addr_i);

    assign cpu_done_o  = (req_q == DONE);
    assign mbus_cmd_o  = mbus_cmd;
    assign mbus_addr_o = mbus_addr;

    mesi_line_table #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_tbl (
        .clk          (clk),
        .rst          (rst),
        .req_ridx_i   (req_idx),
        .req_state_o  (tbl_req_st),
        .req_tag_o    (tbl_req_tag),
        .snp_ridx_i   (snp_idx),
        .snp_state_o  (tbl_snp_st),
        .snp_tag_o    (tbl_snp_tag),
        .snp_we_i     (snp_we),
        .snp_widx_i   (snp_idx),
        .snp_wstate_i (snp_wstate),
        .req_we_i     (req_we),
        .req_widx_i   (req_idx),
        .req_wstate_i (req_wstate),
        .req_wtag_i   (req_wtag)
    );

    always_comb begin
        req_d      = req_q;
        en_ack_d   = 1'b0;
        req_we     = 1'b0;
        req_wstate = tbl_req_st;
        req_wtag   = tbl_req_tag;
        mbus_cmd   = MBUS_NOP;
        mbus_addr  = '0;
        case (req_q)
            IDLE: begin
                if (rdy_q && cpu_req_i && !snp_block) begin
                    if (req_hit && (!cpu_wr_i || tbl_req_st == MESI_M || tbl_req_st == MESI_E)) begin
                        req_d = DONE;
                        if (cpu_wr_i && tbl_req_st == MESI_E) begin
                            req_we     = 1'b1;
                            req_wstate = MESI_M;
                        end
                    end else if (tbl_req_st == MESI_M && tbl_req_tag != req_tag) begin
                        req_d = WB;
                    end else begin
                        req_d = BCAST;
                    end
                end
            end
            WB: begin
                mbus_cmd  = MBUS_WR;
                mbus_addr = {tbl_req_tag, req_idx, 2'b00};
                if (mbus_ack_i) begin
                    req_we     = 1'b1;
                    req_wstate = MESI_I;
                    req_d      = BCAST;
                end
            end
            BCAST: begin
                mbus_cmd  = cpu_wr_i ? MBUS_WR_BROAD : MBUS_RD_BROAD;
                mbus_addr = cpu_addr_i;
                if (mbus_ack_i) begin
                    req_d = WAIT_EN;
                end
            end
            WAIT_EN: begin
                if (en_match) begin
                    en_ack_d   = 1'b1;
                    req_we     = 1'b1;
                    req_wtag   = req_tag;
                    req_wstate = (cbus_cmd_i == CBUS_EN_WR) ? MESI_M : MESI_S;
                    req_d      = DONE;
                end
            end
            DONE:    req_d = IDLE;
            default: req_d = IDLE;
        endcase
    end

    always_comb begin
        snp_d      = snp_q;
        snp_cmd_d  = snp_cmd_q;
        snp_addr_d = snp_addr_q;
        swb_cnt_d  = swb_cnt_q;
        snp_we     = 1'b0;
        snp_wstate = tbl_snp_st;
        case (snp_q)
            S_IDLE: begin
                // Anything not claimed by a pending fill is acked here, including stray ENs.
                if (rdy_q && !cbus_busy && cbus_cmd_i != CBUS_NOP && !en_match) begin
                    snp_cmd_d  = cbus_cmd_i;
                    snp_addr_d = cbus_addr_i;
                    swb_cnt_d  = '0;
                    if (is_snoop(cbus_cmd_i) && snp_hit && tbl_snp_st == MESI_M) begin
                        snp_d = S_WB;
                    end else begin
                        snp_d = S_ACK;
                    end
                end
            end
            S_WB: begin
                if (swb_cnt_q == SWB_LAST) begin
                    snp_d = S_ACK;
                end else begin
                    swb_cnt_d = swb_cnt_q + 1'b1;
                end
            end
            S_ACK: begin
                snp_d = S_IDLE;
                if (snp_hit) begin
                    if (snp_cmd_q == CBUS_WR_SNOOP) begin
                        snp_we     = 1'b1;
                        snp_wstate = MESI_I;
                    end else if (snp_cmd_q == CBUS_RD_SNOOP &&
                                 (tbl_snp_st == MESI_M || tbl_snp_st == MESI_E)) begin
                        snp_we     = 1'b1;
                        snp_wstate = MESI_S;
                    end
                end
            end
            default: snp_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= IDLE;
            snp_q      <= S_IDLE;
            rdy_q      <= 1'b0;
            en_ack_q   <= 1'b0;
            cbus_ign_q <= 1'b0;
            snp_cmd_q  <= '0;
            snp_addr_q <= '0;
            swb_cnt_q  <= '0;
        end else begin
            req_q      <= req_d;
            snp_q      <= snp_d;
            rdy_q      <= 1'b1;
            en_ack_q   <= en_ack_d;
            cbus_ign_q <= cbus_ack_o;
            snp_cmd_q  <= snp_cmd_d;
            snp_addr_q <= snp_addr_d;
            swb_cnt_q  <= swb_cnt_d;
        end
    end

endmodule

// File: tb/tb_mesi_cpu_agent.sv
// Directed bench for mesi_cpu_agent: miss/fill, hits, writeback, snoops and reset abort.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_mesi_cpu_agent;
    import mesi_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req_i = 1'b0;
    logic          cpu_wr_i = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic          cpu_done_o;
    logic [2:0]    mbus_cmd_o;
    logic [AW-1:0] mbus_addr_o;
    logic          mbus_ack_i = 1'b0;
    logic [2:0]    cbus_cmd_i = '0;
    logic [AW-1:0] cbus_addr_i = '0;
    logic          cbus_ack_o;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mesi_cpu_agent #(
        .ADDR_WIDTH (AW),
        .LINES      (16),
        .WB_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req_i),
        .cpu_wr_i    (cpu_wr_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_done_o  (cpu_done_o),
        .mbus_cmd_o  (mbus_cmd_o),
        .mbus_addr_o (mbus_addr_o),
        .mbus_ack_i  (mbus_ack_i),
        .cbus_cmd_i  (cbus_cmd_i),
        .cbus_addr_i (cbus_addr_i),
        .cbus_ack_o  (cbus_ack_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // All test addresses map to index 0 (addr[5:2] == 0).
    task automatic chk_line(input string tag, input logic [1:0] st, input logic [25:0] tg);
        chk({tag, "_state"}, 64'(dut.u_tbl.state_q[0]), 64'(st));
        chk({tag, "_tag"}, 64'(dut.u_tbl.tag_q[0]), 64'(tg));
    endtask

    task automatic snoop(input logic [2:0] cmd, input logic [AW-1:0] addr, input int exp_lat);
        int   lat;
        logic got;
        lat = 0;
        got = 1'b0;
        cbus_cmd_i  = cmd;
        cbus_addr_i = addr;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = cbus_ack_o;
        end
        chk("snp_ack_seen", 64'(got), 64'd1);
        chk("snp_ack_lat", 64'(lat), 64'(exp_lat));
        @(negedge clk);
        chk("snp_ack_once", 64'(cbus_ack_o), 64'd0);
        cbus_cmd_i = '0;
        @(negedge clk);
        chk("snp_ack_after_drop", 64'(cbus_ack_o), 64'd0);
    endtask

    task automatic miss(input logic wr, input logic [AW-1:0] addr, input logic exp_wb,
                        input logic [AW-1:0] vaddr, input logic snp_in_wait);
        cpu_req_i  = 1'b1;
        cpu_wr_i   = wr;
        cpu_addr_i = addr;
        @(negedge clk);
        if (exp_wb) begin
            chk("wb_cmd", 64'(mbus_cmd_o), 64'd1);
            chk("wb_addr", 64'(mbus_addr_o), 64'(vaddr));
            @(negedge clk);
            chk("wb_hold", 64'(mbus_cmd_o), 64'd1);
            mbus_ack_i = 1'b1;
            @(negedge clk);
            mbus_ack_i = 1'b0;
            chk("wb_victim_inval", 64'(dut.u_tbl.state_q[0]), 64'(MESI_I));
        end
        chk("bc_cmd", 64'(mbus_cmd_o), wr ? 64'd3 : 64'd4);
        chk("bc_addr", 64'(mbus_addr_o), 64'(addr));
        @(negedge clk);
        chk("bc_hold", 64'(mbus_cmd_o), wr ? 64'd3 : 64'd4);
        mbus_ack_i = 1'b1;
        @(negedge clk);
        mbus_ack_i = 1'b0;
        chk("wait_nop", 64'(mbus_cmd_o), 64'd0);
        chk("wait_addr0", 64'(mbus_addr_o), 64'd0);
        if (snp_in_wait) begin
            snoop(CBUS_WR_SNOOP, 32'h80, 1);
            chk("wait_after_snp_done", 64'(cpu_done_o), 64'd0);
        end
        cbus_cmd_i  = wr ? CBUS_EN_WR : CBUS_EN_RD;
        cbus_addr_i = addr;
        @(negedge clk);
        chk("en_ack", 64'(cbus_ack_o), 64'd1);
        chk("fill_done", 64'(cpu_done_o), 64'd1);
        cpu_req_i = 1'b0;
        @(negedge clk);
        chk("en_ack_once", 64'(cbus_ack_o), 64'd0);
        chk("done_once", 64'(cpu_done_o), 64'd0);
        cbus_cmd_i = '0;
        @(negedge clk);
        chk("en_ack_after_drop", 64'(cbus_ack_o), 64'd0);
    endtask

    task automatic hit(input logic wr, input logic [AW-1:0] addr);
        cpu_req_i  = 1'b1;
        cpu_wr_i   = wr;
        cpu_addr_i = addr;
        @(negedge clk);
        chk("hit_done", 64'(cpu_done_o), 64'd1);
        chk("hit_no_mbus", 64'(mbus_cmd_o), 64'd0);
        cpu_req_i = 1'b0;
        @(negedge clk);
        chk("hit_done_once", 64'(cpu_done_o), 64'd0);
    endtask

    initial begin
        int swb_lat;
`ifdef MESI_SNOOP_WB_EN
        swb_lat = 5;
`else
        swb_lat = 2;
`endif
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(cpu_done_o), 64'd0);
        chk("rst_cbus_ack", 64'(cbus_ack_o), 64'd0);
        chk("rst_mbus_cmd", 64'(mbus_cmd_o), 64'd0);
        chk("rst_mbus_addr", 64'(mbus_addr_o), 64'd0);
        chk_line("rst_line", MESI_I, 26'h0);

        // Read 0x40 requested as reset releases: must not be taken on the first edge.
        rst        = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h40;
        @(negedge clk);
        chk("first_edge_idle", 64'(mbus_cmd_o), 64'd0);
        miss(1'b0, 32'h40, 1'b0, '0, 1'b0);
        chk_line("rd_fill", MESI_S, 26'h1);

        snoop(CBUS_EN_RD, 32'h40, 1);
        chk_line("stray_en", MESI_S, 26'h1);

        miss(1'b1, 32'h40, 1'b0, '0, 1'b0);
        chk_line("wr_fill", MESI_M, 26'h1);
        hit(1'b1, 32'h40);
        chk_line("wr_hit_m", MESI_M, 26'h1);

        snoop(CBUS_RD_SNOOP, 32'h40, swb_lat);
        chk_line("rd_snoop_m", MESI_S, 26'h1);
        hit(1'b0, 32'h40);

        miss(1'b1, 32'h40, 1'b0, '0, 1'b0);
        chk_line("refill_m", MESI_M, 26'h1);
        miss(1'b0, 32'h440, 1'b1, 32'h40, 1'b0);
        chk_line("evict_fill", MESI_S, 26'h11);

        miss(1'b0, 32'h40, 1'b0, '0, 1'b1);
        chk_line("fill_after_snoop", MESI_S, 26'h1);

        snoop(CBUS_WR_SNOOP, 32'h80, 1);
        chk_line("wr_snoop_miss", MESI_S, 26'h1);
        snoop(CBUS_WR_SNOOP, 32'h40, 1);
        chk_line("wr_snoop_hit", MESI_I, 26'h1);

        // Reset while broadcasting a read.
        cpu_req_i  = 1'b1;
        cpu_wr_i   = 1'b0;
        cpu_addr_i = 32'h40;
        @(negedge clk);
        chk("abort_bcast", 64'(mbus_cmd_o), 64'd4);
        rst = 1'b0;
        #1;
        chk("abort_mbus_cmd", 64'(mbus_cmd_o), 64'd0);
        chk("abort_mbus_addr", 64'(mbus_addr_o), 64'd0);
        chk("abort_done", 64'(cpu_done_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 64'(cpu_done_o), 64'd0);
        end
        chk_line("abort_line", MESI_I, 26'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
